mem_rmw_ctrl: RTL and testbench
===============================

MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, giving the RAM word-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  CPU load/store request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  ADDR_WIDTH+2  byte address.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned  input  1  zero-extend loads when 1.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  request was misaligned or used reserved size.
REQ-014 SHALL have ports ram_raddr/ram_waddr  output  ADDR_WIDTH, ram_we  output  1, ram_din  output  32, ram_dout  input  32, connecting to the 32-bit dual-port word RAM.

Function
REQ-015 SHALL implement two states: IDLE (req_ready=1) and ACCESS (req_ready=0).
REQ-016 SHALL, in IDLE, drive ram_raddr = req_addr[ADDR_WIDTH+1:2] combinationally; on acceptance, latch all req_* fields and go to ACCESS.
REQ-017 SHALL treat ram_dout as valid exactly one cycle after ram_raddr is presented.
REQ-018 SHALL, in ACCESS, assert rsp_valid for exactly one cycle and return to IDLE unconditionally; the response therefore arrives 1 cycle after acceptance, and throughput is 1 request per 2 cycles.
REQ-019 SHALL, for a load in ACCESS, select little-endian lane addr[1:0] (byte) or addr[1] (half) from ram_dout, then sign-extend it, or zero-extend it when req_unsigned=1.
REQ-020 SHALL, for a store in ACCESS, assert ram_we=1, drive ram_waddr = the latched word address, and drive ram_din = ram_dout with only the addressed lanes replaced by req_wdata low bits (read-modify-write).
REQ-021 SHALL drive ram_we=0 in IDLE, in error cycles, and whenever rst=1.
REQ-022 SHALL flag rsp_err=1 and perform no RAM write for req_size=11, in all builds.
REQ-023 SHALL hold rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.
REQ-024 SHALL support back-to-back requests: a load issued in the IDLE cycle immediately following a store to the same word returns the newly stored data.

Reset
REQ-025 SHALL, while rst=1, force the state to IDLE and drive rsp_valid=0, rsp_err=0, rsp_rdata=0 and ram_we=0; req_ready SHALL read 1 after reset.
REQ-026 SHALL abort an in-flight ACCESS when rst is asserted in that cycle, producing no write and no response.

Configuration
REQ-027 SHALL, with macro MEM_ALIGN_CHECK_EN defined, flag rsp_err=1 with no RAM write for half accesses with addr[0]=1 and word accesses with addr[1:0]!=00.
REQ-028 SHALL, without MEM_ALIGN_CHECK_EN, ignore addr[0] for half accesses and addr[1:0] for word accesses (forced alignment), and never raise rsp_err except under REQ-022.

Verification
REQ-029 SHALL cover: word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid 1 cycle after each acceptance.
REQ-030 SHALL cover: byte store 0x5A to addr 0x11 over word 0xDEADBEEF -> word becomes 0xDEAD5AEF; then signed byte load from 0x13 -> 0xFFFFFFDE, and unsigned -> 0x000000DE.
REQ-031 SHALL cover: half store 0x1234 to addr 0x12 -> word becomes 0x12345AEF; then signed half load from 0x12 -> 0x00001234.
REQ-032 SHALL cover: word load from 0x11 -> with MEM_ALIGN_CHECK_EN, rsp_err=1 and rsp_rdata=0; without it, rsp_rdata = the word at 0x10.
REQ-033 SHALL cover: rst asserted in the ACCESS cycle of a store -> ram_we=0, no rsp_valid, RAM word unchanged, req_ready=1 the next cycle.
REQ-034 SHALL cover: req_valid held high continuously for 4 requests -> req_ready toggles 1,0,1,0 and exactly 4 rsp_valid pulses are produced.

Source files
------------

// File: rtl/mem_rmw_ctrl.sv
// Two-state load/store controller for a 32-bit dual-port word RAM, with sub-word
// read-modify-write stores. Define MEM_ALIGN_CHECK_EN to flag misaligned half/word accesses.
module mem_rmw_ctrl #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic                  lat_we;
  logic                  lat_unsigned;
  logic                  lat_err;
  logic [1:0]            lat_size;
  logic [ADDR_WIDTH+1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic                  req_err;
  logic                  active;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_val;
  logic [31:0]           merged;

  always_comb begin
    req_err = (req_size == 2'b11);
`ifdef MEM_ALIGN_CHECK_EN
    if ((req_size == 2'b01) && req_addr[0])
      req_err = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_err      <= 1'b0;
      lat_size     <= 2'b00;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_unsigned <= req_unsigned;
            lat_err      <= req_err;
            lat_size     <= req_size;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            state        <= ACCESS;
          end
        end
        ACCESS:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response and write strobes are gated by rst so a reset in ACCESS aborts the access outright.
  assign active    = (state == ACCESS) && !rst;
  assign req_ready = (state == IDLE);
  assign ram_raddr = (state == IDLE) ? req_addr[ADDR_WIDTH+1:2] : lat_addr[ADDR_WIDTH+1:2];
  assign ram_waddr = lat_addr[ADDR_WIDTH+1:2];

  // One lane decode serves both the load extractor and the store merge path.
  always_comb begin
    load_val = '0;
    merged   = ram_dout;
    byte_sel = ram_dout[{lat_addr[1:0], 3'b000} +: 8];
    half_sel = lat_addr[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (lat_size)
      2'b00: begin
        load_val = {{24{~lat_unsigned & byte_sel[7]}}, byte_sel};
        merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
      end
      2'b01: begin
        load_val = {{16{~lat_unsigned & half_sel[15]}}, half_sel};
        if (lat_addr[1])
          merged[31:16] = lat_wdata[15:0];
        else
          merged[15:0] = lat_wdata[15:0];
      end
      2'b10: begin
        load_val = ram_dout;
        merged   = lat_wdata;
      end
      default: begin
        load_val = '0;
        merged   = ram_dout;
      end
    endcase
  end

  assign rsp_valid = active;
  assign rsp_err   = active && lat_err;
  assign rsp_rdata = (active && !lat_we && !lat_err) ? load_val : 32'h0;
  assign ram_we    = active && lat_we && !lat_err;
  assign ram_din   = merged;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Self-checking bench for mem_rmw_ctrl: directed scenarios plus random traffic checked
// against a byte-addressed memory model. Honours MEM_ALIGN_CHECK_EN when defined.
module tb_mem_rmw_ctrl;

  localparam int AW = 6;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW+1:0] req_addr;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_raddr;
  logic [AW-1:0] ram_waddr;
  logic          ram_we;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [7:0]    refMem [0:(4<<AW)-1];
  logic          tbInitWe;
  logic [AW-1:0] tbInitAddr;
  logic [31:0]   tbInitData;

  int assertCount;
  int failCount;

  mem_rmw_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port word RAM with one-cycle registered read; the bench preloads it through its own port.
  always @(posedge clk) begin
    if (tbInitWe)
      mem[tbInitAddr] <= tbInitData;
    else if (ram_we)
      mem[ram_waddr] <= ram_din;
    ram_dout <= mem[ram_raddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelWord(input int idx);
    return {refMem[4*idx+3], refMem[4*idx+2], refMem[4*idx+1], refMem[4*idx]};
  endfunction

  function automatic logic modelErr(input logic [AW+1:0] addr, input logic [1:0] size);
    logic e;
    e = (size == 2'b11);
`ifdef MEM_ALIGN_CHECK_EN
    if (size == 2'b01 && addr[0]) e = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [AW+1:0] addr, input logic [1:0] size, input logic uns);
    int n;
    int base;
    longint v;
    n    = 1 << size;
    base = int'(addr) & ~(n - 1);
    v    = 0;
    for (int i = 0; i < n; i++)
      v = v | (longint'(refMem[base+i]) << (8*i));
    if (!uns && n < 4 && ((v >> (8*n-1)) & 1) == 1)
      v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic modelStore(input logic [AW+1:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    int n;
    int base;
    n    = 1 << size;
    base = int'(addr) & ~(n - 1);
    for (int i = 0; i < n; i++)
      refMem[base+i] = 8'(wdata >> (8*i));
  endtask

  // One request from an IDLE cycle through its response; leaves the bench in the next IDLE cycle.
  task automatic applyStimulus(input logic we, input logic [AW+1:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, output logic [31:0] obsData);
    logic        err;
    logic [31:0] exp;
    int          widx;
    err  = modelErr(addr, size);
    exp  = (!err && !we) ? modelLoad(addr, size, uns) : 32'h0;
    widx = int'(addr[AW+1:2]);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    checkOutput("ready_idle", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    obsData = rsp_rdata;
    checkOutput("rsp_valid", {31'b0, rsp_valid}, 32'h1);
    checkOutput("ready_access", {31'b0, req_ready}, 32'h0);
    checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, err});
    checkOutput("rsp_rdata", rsp_rdata, exp);
    checkOutput("ram_we", {31'b0, ram_we}, {31'b0, we && !err});
    if (we && !err) modelStore(addr, size, wdata);
    @(posedge clk); #1;
    checkOutput("rsp_valid_drop", {31'b0, rsp_valid}, 32'h0);
    checkOutput("ram_word", mem[widx], modelWord(widx));
  endtask

  initial begin
    logic [31:0] d;
    int          pulses;
    assertCount = 0;
    failCount   = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
    tbInitWe = 1'b0; tbInitAddr = '0; tbInitData = '0;

    // Preload RAM and model with the same random contents while reset holds the DUT idle.
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      tbInitWe   = 1'b1;
      tbInitAddr = AW'(i);
      tbInitData = $urandom;
      for (int b = 0; b < 4; b++)
        refMem[4*i+b] = 8'(tbInitData >> (8*b));
    end
    @(negedge clk);
    tbInitWe = 1'b0;
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_ram_we", {31'b0, ram_we}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_ready", {31'b0, req_ready}, 32'h1);

    $display("[TB] directed word/byte/half scenarios");
    applyStimulus(1'b1, 8'h10, 2'b10, 1'b0, 32'hDEADBEEF, d);
    applyStimulus(1'b0, 8'h10, 2'b10, 1'b0, 32'h0, d);
    checkOutput("word_load_10", d, 32'hDEADBEEF);
    applyStimulus(1'b1, 8'h11, 2'b00, 1'b0, 32'h0000005A, d);
    checkOutput("byte_merge", mem[4], 32'hDEAD5AEF);
    applyStimulus(1'b0, 8'h13, 2'b00, 1'b0, 32'h0, d);
    checkOutput("byte_signed", d, 32'hFFFFFFDE);
    applyStimulus(1'b0, 8'h13, 2'b00, 1'b1, 32'h0, d);
    checkOutput("byte_unsigned", d, 32'h000000DE);
    applyStimulus(1'b1, 8'h12, 2'b01, 1'b0, 32'h00001234, d);
    checkOutput("half_merge", mem[4], 32'h12345AEF);
    applyStimulus(1'b0, 8'h12, 2'b01, 1'b0, 32'h0, d);
    checkOutput("half_signed", d, 32'h00001234);
    applyStimulus(1'b0, 8'h11, 2'b10, 1'b0, 32'h0, d);
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("misaligned_word", d, 32'h0);
`else
    checkOutput("forced_align_word", d, 32'h12345AEF);
`endif
    applyStimulus(1'b1, 8'h14, 2'b11, 1'b0, 32'hCAFEF00D, d);

    $display("[TB] reset during store access");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_size = 2'b10; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("abort_ram_we", {31'b0, ram_we}, 32'h0);
    checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("abort_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("abort_rsp_after", {31'b0, rsp_valid}, 32'h0);
    checkOutput("abort_word", mem[8], modelWord(8));

    $display("[TB] continuous req_valid for four loads");
    pulses = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_size = 2'b10; req_unsigned = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream_ready", {31'b0, req_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
      if (rsp_valid) pulses++;
      if (i == 7) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    if (rsp_valid) pulses++;
    checkOutput("stream_pulses", 32'(pulses), 32'd4);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++)
      applyStimulus(1'($urandom), 8'($urandom_range(0, 31)), 2'($urandom), 1'($urandom), $urandom, d);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
